// File: rtl/bram_sdp_be_clr.sv
// ----------------------------------------------------------------------------
// bram_sdp_be_clr
// Simple-dual-port block RAM on one clock: port A writes with per-byte
// enables, port B reads with 1 or 2 cycles of latency. A clear engine
// zero-fills the whole array, one word per cycle, on request.
//
// Ports
//   clka        : clock, rising edge
//   rsta        : synchronous active-high reset (array contents untouched)
//   addra/dina  : write address / data
//   wea         : byte write enables, bit i covers dina[8i+7:8i]
//   rdenb/addrb : read request / address, sampled on the same edge
//   doutb       : read data, holds its last value between reads
//   doutb_valid : one-cycle pulse marking a fresh read result
//   clr_req     : start zero-fill (sampled only while idle)
//   clr_busy    : high for the DEPTH cycles of a clear
//
// Read timing: rdenb sampled high at edge N gives doutb/doutb_valid right
// after edge N (OUT_REG=0) or right after edge N+1 (OUT_REG=1).
// ----------------------------------------------------------------------------
module bram_sdp_be_clr #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OUT_REG    = 0,
   parameter int unsigned BYPASS     = 1,
   parameter string       INIT_FILE  = ""
) (
   input  logic                    clka,
   input  logic                    rsta,
   input  logic [ADDR_WIDTH-1:0]   addra,
   input  logic [DATA_WIDTH-1:0]   dina,
   input  logic [DATA_WIDTH/8-1:0] wea,
   input  logic                    rdenb,
   input  logic [ADDR_WIDTH-1:0]   addrb,
   output logic [DATA_WIDTH-1:0]   doutb,
   output logic                    doutb_valid,
   input  logic                    clr_req,
   output logic                    clr_busy
);

   localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
   localparam int unsigned NB_LANES = DATA_WIDTH / 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;

   logic                  clr_wr;
   logic [NB_LANES-1:0]   wr_be;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] rd_data_q;
   logic                  rd_valid_q;

   // Clear engine: one word per cycle from 0 to DEPTH-1, no restart while busy.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_req) begin
                  state_q   <= ST_CLEAR;
                  clr_cnt_q <= '0;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                  state_q <= ST_IDLE;
               end else begin
                  clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign clr_busy = (state_q == ST_CLEAR);

   // Write-port mux: the clear engine owns port A while busy; a reset edge
   // during a clear performs no clear write so the abort leaves the word intact.
   always_comb begin
      clr_wr  = (state_q == ST_CLEAR) && !rsta;
      wr_be   = wea;
      wr_addr = addra;
      wr_data = dina;
      if (clr_wr) begin
         wr_be   = '1;
         wr_addr = clr_cnt_q;
         wr_data = '0;
      end
   end

   // Byte-lane writes into the array.
   always_ff @(posedge clka) begin
      for (int i = 0; i < int'(NB_LANES); i++) begin
         if (wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Read word with optional per-lane write-first forwarding on a collision.
   always_comb begin
      rd_word = mem[addrb];
      if ((BYPASS != 0) && (wr_addr == addrb)) begin
         for (int i = 0; i < int'(NB_LANES); i++) begin
            if (wr_be[i]) begin
               rd_word[8*i +: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   // First read stage: captures only on a request so doutb holds between reads.
   always_ff @(posedge clka) begin
      if (rsta) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rdenb;
         if (rdenb) begin
            rd_data_q <= rd_word;
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] out_data_q;
         logic                  out_valid_q;

         // Second read stage, advancing only on a fresh first-stage result.
         always_ff @(posedge clka) begin
            if (rsta) begin
               out_data_q  <= '0;
               out_valid_q <= 1'b0;
            end else begin
               out_valid_q <= rd_valid_q;
               if (rd_valid_q) begin
                  out_data_q <= rd_data_q;
               end
            end
         end

         assign doutb       = out_data_q;
         assign doutb_valid = out_valid_q;
      end else begin : g_no_out_reg
         assign doutb       = rd_data_q;
         assign doutb_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_bram_sdp_be_clr.sv
// ----------------------------------------------------------------------------
// tb_bram_sdp_be_clr
// Directed bench driving two instances from the same stimulus:
//   u_dut_a : OUT_REG=0, BYPASS=1 (latency 1, write-first)
//   u_dut_b : OUT_REG=1, BYPASS=0 (latency 2, read-first)
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_bram_sdp_be_clr;

   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rsta;
   logic [AW-1:0] addra;
   logic [DW-1:0] dina;
   logic [3:0]    wea;
   logic          rdenb;
   logic [AW-1:0] addrb;
   logic          clr_req;

   logic [DW-1:0] dout_a, dout_b;
   logic          vld_a, vld_b;
   logic          busy_a, busy_b;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   bram_sdp_be_clr #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .BYPASS(1), .INIT_FILE("")
   ) u_dut_a (
      .clka(clk), .rsta(rsta), .addra(addra), .dina(dina), .wea(wea),
      .rdenb(rdenb), .addrb(addrb), .doutb(dout_a), .doutb_valid(vld_a),
      .clr_req(clr_req), .clr_busy(busy_a)
   );

   bram_sdp_be_clr #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .BYPASS(0), .INIT_FILE("")
   ) u_dut_b (
      .clka(clk), .rsta(rsta), .addra(addra), .dina(dina), .wea(wea),
      .rdenb(rdenb), .addrb(addrb), .doutb(dout_b), .doutb_valid(vld_b),
      .clr_req(clr_req), .clr_busy(busy_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      addra = a;
      dina  = d;
      wea   = be;
      step();
      wea   = 4'h0;
   endtask

   // Single read checked on both instances at their own latency.
   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      rdenb = 1'b1;
      addrb = a;
      step();
      rdenb = 1'b0;
      chk({tag, "_a"}, dout_a, exp);
      chk({tag, "_a_vld"}, 32'(vld_a), 32'd1);
      step();
      chk({tag, "_b"}, dout_b, exp);
      chk({tag, "_b_vld"}, 32'(vld_b), 32'd1);
   endtask

   initial begin
      rsta    = 1'b1;
      addra   = '0;
      dina    = '0;
      wea     = 4'h0;
      rdenb   = 1'b0;
      addrb   = '0;
      clr_req = 1'b0;

      // Reset state
      step();
      step();
      rsta = 1'b0;
      chk("rst_dout_a", dout_a, 32'h0);
      chk("rst_vld_a", 32'(vld_a), 32'd0);
      chk("rst_busy_a", 32'(busy_a), 32'd0);
      chk("rst_dout_b", dout_b, 32'h0);
      chk("rst_vld_b", 32'(vld_b), 32'd0);
      chk("rst_busy_b", 32'(busy_b), 32'd0);

      // Byte lanes and latency: single-cycle read pulse at 0x010
      wr(8'h10, 32'hA1B2C3D4, 4'hF);
      wr(8'h10, 32'h000000EE, 4'h1);
      rdenb = 1'b1;
      addrb = 8'h10;
      step();
      rdenb = 1'b0;
      chk("lat1_vld_a", 32'(vld_a), 32'd1);
      chk("lat1_dout_a", dout_a, 32'hA1B2C3EE);
      chk("lat1_vld_b", 32'(vld_b), 32'd0);
      step();
      chk("lat2_vld_a", 32'(vld_a), 32'd0);
      chk("lat2_hold_a", dout_a, 32'hA1B2C3EE);
      chk("lat2_vld_b", 32'(vld_b), 32'd1);
      chk("lat2_dout_b", dout_b, 32'hA1B2C3EE);
      step();
      chk("lat3_vld_b", 32'(vld_b), 32'd0);
      chk("lat3_hold_b", dout_b, 32'hA1B2C3EE);

      // Collision: write lanes 0-1 and read the same word on one edge
      wr(8'h20, 32'h11111111, 4'hF);
      addra = 8'h20;
      dina  = 32'hFFFFFFFF;
      wea   = 4'h3;
      rdenb = 1'b1;
      addrb = 8'h20;
      step();
      wea   = 4'h0;
      rdenb = 1'b0;
      chk("coll_bypass_a", dout_a, 32'h1111FFFF);
      step();
      chk("coll_rdfirst_b", dout_b, 32'h11111111);
      rd_chk("coll_after", 8'h20, 32'h1111FFFF);

      // Clear: fill some words, then zero-fill the array
      wr(8'h05, 32'hDEADBEEF, 4'hF);
      wr(8'hFF, 32'h12345678, 4'hF);
      clr_req = 1'b1;
      step();
      chk("clr_start_busy_a", 32'(busy_a), 32'd1);
      n = 0;
      while (busy_a === 1'b1 && n < int'(DEPTH) + 8) begin
         n++;
         if (n == 20) clr_req = 1'b0;
         if (n == 50) begin
            addra = 8'h05;
            dina  = 32'hCAFEF00D;
            wea   = 4'hF;
         end
         if (n == 51) wea = 4'h0;
         if (n == int'(DEPTH)) begin
            rdenb = 1'b1;
            addrb = 8'hFF;
         end
         step();
      end
      rdenb = 1'b0;
      chk("clr_busy_cycles", 32'(n), 32'(DEPTH));
      chk("clr_end_busy_b", 32'(busy_b), 32'd0);
      chk("clr_last_bypass_a", dout_a, 32'h0);
      chk("clr_last_vld_a", 32'(vld_a), 32'd1);
      step();
      chk("clr_last_rdfirst_b", dout_b, 32'h12345678);
      chk("clr_last_vld_b", 32'(vld_b), 32'd1);
      rd_chk("clr_w05", 8'h05, 32'h0);
      rd_chk("clr_w10", 8'h10, 32'h0);
      rd_chk("clr_w20", 8'h20, 32'h0);
      rd_chk("clr_wff", 8'hFF, 32'h0);

      // Abort: reset on the 101st clear edge
      wr(8'h63, 32'hAAAA0063, 4'hF);
      wr(8'h64, 32'hBBBB0064, 4'hF);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (100) step();
      chk("abort_pre_busy_a", 32'(busy_a), 32'd1);
      rsta = 1'b1;
      step();
      rsta = 1'b0;
      chk("abort_busy_a", 32'(busy_a), 32'd0);
      chk("abort_busy_b", 32'(busy_b), 32'd0);
      rd_chk("abort_w63", 8'h63, 32'h0);
      rd_chk("abort_w64", 8'h64, 32'hBBBB0064);

      // Reset in the middle of a back-to-back read stream
      wr(8'h65, 32'hCCCC0065, 4'hF);
      rdenb = 1'b1;
      addrb = 8'h64;
      step();
      chk("strm0_a", dout_a, 32'hBBBB0064);
      addrb = 8'h65;
      step();
      chk("strm1_a", dout_a, 32'hCCCC0065);
      chk("strm1_b", dout_b, 32'hBBBB0064);
      chk("strm1_vld_b", 32'(vld_b), 32'd1);
      rsta = 1'b1;
      step();
      chk("strm_rst_dout_a", dout_a, 32'h0);
      chk("strm_rst_vld_a", 32'(vld_a), 32'd0);
      chk("strm_rst_dout_b", dout_b, 32'h0);
      chk("strm_rst_vld_b", 32'(vld_b), 32'd0);
      rsta  = 1'b0;
      rdenb = 1'b0;
      step();
      chk("strm_post_vld_b", 32'(vld_b), 32'd0);
      rd_chk("rst_keep_w65", 8'h65, 32'hCCCC0065);
      rd_chk("rst_keep_w64", 8'h64, 32'hBBBB0064);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
